// File: rtl/secuenciador_mac.sv
// rtl/secuenciador_mac.sv - time-multiplexed FIR MAC controller with saturating output (optional rounding: SECUENCIADOR_MAC_REDONDEO_EN)
module secuenciador_mac #(
    parameter int ANCHO      = 16,
    parameter int RESOLUCION = 8,
    parameter int N_TAPS     = 4,
    parameter int GUARDA     = $clog2(N_TAPS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      coef_we,
    input  logic [$clog2(N_TAPS)-1:0] coef_addr,
    input  logic [ANCHO-1:0]          coef_dato,
    input  logic [ANCHO-1:0]          muestra_in,
    input  logic                      muestra_valida,
    output logic                      ocupado,
    output logic [ANCHO-1:0]          salida,
    output logic                      salida_valida,
    output logic                      overflow
);
    localparam int AW     = $clog2(N_TAPS);
    localparam int PROD_W = 2 * ANCHO;
    localparam int ACC_W  = 2 * ANCHO + GUARDA;

    typedef enum logic [1:0] {
        REPOSO,
        MAC,
        SATURA
    } estado_t;

    estado_t estado, estado_sig;

    logic signed [ANCHO-1:0]  x [N_TAPS];
    logic signed [ANCHO-1:0]  c [N_TAPS];
    logic [AW-1:0]            indice;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] producto;
    logic signed [ACC_W-1:0]  acc_sat;
    logic signed [ACC_W-1:0]  desplazado;
    logic                     cabe;

    // Shared multiplier: operands are sign-extended first so the full product is exact
    always_comb begin
        producto = PROD_W'(x[indice]) * PROD_W'(c[indice]);
    end

    // Accumulator conditioning before the slice; the shift keeps the sign so every
    // bit above the candidate word must match the candidate's MSB for it to fit
    always_comb begin
`ifdef SECUENCIADOR_MAC_REDONDEO_EN
        acc_sat = acc + (ACC_W'(1) << (RESOLUCION - 1));
`else
        acc_sat = acc;
`endif
        desplazado = acc_sat >>> RESOLUCION;
        cabe = (&desplazado[ACC_W-1:ANCHO-1]) | ~(|desplazado[ACC_W-1:ANCHO-1]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    // Next-state and busy flag
    always_comb begin
        estado_sig = estado;
        ocupado    = 1'b1;
        case (estado)
            REPOSO: begin
                ocupado = 1'b0;
                if (muestra_valida) begin
                    estado_sig = MAC;
                end
            end
            MAC: begin
                if (indice == AW'(N_TAPS - 1)) begin
                    estado_sig = SATURA;
                end
            end
            SATURA: begin
                estado_sig = REPOSO;
            end
            default: begin
                estado_sig = REPOSO;
            end
        endcase
    end

    // Delay line, coefficient bank, accumulation and saturated output register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_TAPS; k++) begin
                x[k] <= '0;
                c[k] <= '0;
            end
            acc           <= '0;
            indice        <= '0;
            salida        <= '0;
            salida_valida <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            salida_valida <= 1'b0;
            // Coefficients only change while idle so a computation sees a stable bank
            if (coef_we && estado == REPOSO) begin
                c[coef_addr] <= coef_dato;
            end
            case (estado)
                REPOSO: begin
                    if (muestra_valida) begin
                        x[0] <= muestra_in;
                        for (int k = 1; k < N_TAPS; k++) begin
                            x[k] <= x[k-1];
                        end
                        acc    <= '0;
                        indice <= '0;
                    end
                end
                MAC: begin
                    acc    <= acc + ACC_W'(producto);
                    indice <= indice + 1'b1;
                end
                SATURA: begin
                    if (cabe) begin
                        salida   <= desplazado[ANCHO-1:0];
                        overflow <= 1'b0;
                    end else if (!desplazado[ACC_W-1]) begin
                        salida   <= {1'b0, {(ANCHO-1){1'b1}}};
                        overflow <= 1'b1;
                    end else begin
                        salida   <= {1'b1, {(ANCHO-1){1'b0}}};
                        overflow <= 1'b1;
                    end
                    salida_valida <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_secuenciador_mac.sv
// tb/tb_secuenciador_mac.sv - scoreboard bench for secuenciador_mac with randomized stimulus
module tb_secuenciador_mac;
    localparam int ANCHO      = 16;
    localparam int RESOLUCION = 8;
    localparam int N_TAPS     = 4;
    localparam int AW         = $clog2(N_TAPS);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             coef_we = 1'b0;
    logic [AW-1:0]    coef_addr = '0;
    logic [ANCHO-1:0] coef_dato = '0;
    logic [ANCHO-1:0] muestra_in = '0;
    logic             muestra_valida = 1'b0;
    logic             ocupado;
    logic [ANCHO-1:0] salida;
    logic             salida_valida;
    logic             overflow;

    secuenciador_mac #(
        .ANCHO(ANCHO), .RESOLUCION(RESOLUCION), .N_TAPS(N_TAPS)
    ) dut (
        .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_dato(coef_dato), .muestra_in(muestra_in), .muestra_valida(muestra_valida),
        .ocupado(ocupado), .salida(salida), .salida_valida(salida_valida), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ANCHO-1:0] s;
        logic             o;
        int               acc_edge;
    } exp_t;

    exp_t                    exp_q[$];
    logic signed [ANCHO-1:0] xm [N_TAPS];
    logic signed [ANCHO-1:0] cm [N_TAPS];
    logic [ANCHO-1:0]        held_s = '0;
    logic                    held_o = 1'b0;
    int                      edge_n = 0;
    int                      free_edge = 0;
    int                      checks = 0;
    int                      errors = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, edge_n, act, req);
        end
    endtask

    // Filter output from the arithmetic definition: exact dot product, floor (or
    // round-half-up) scaling, then clamp to the signed output range
    function automatic exp_t modelo(input int acc_edge);
        exp_t   e;
        longint s = 0;
        for (int i = 0; i < N_TAPS; i++) s += longint'(xm[i]) * longint'(cm[i]);
`ifdef SECUENCIADOR_MAC_REDONDEO_EN
        s += longint'(1) << (RESOLUCION - 1);
`endif
        s = s >>> RESOLUCION;
        if (s > 32767) begin
            e.s = 16'h7FFF; e.o = 1'b1;
        end else if (s < -32768) begin
            e.s = 16'h8000; e.o = 1'b1;
        end else begin
            e.s = s[ANCHO-1:0]; e.o = 1'b0;
        end
        e.acc_edge = acc_edge;
        return e;
    endfunction

    // One clock cycle of stimulus; the model applies the same inputs at the edge
    task automatic cyc(input logic r, input logic we, input logic [AW-1:0] a,
                       input logic [ANCHO-1:0] d, input logic mv, input logic [ANCHO-1:0] m);
        reset = r; coef_we = we; coef_addr = a; coef_dato = d;
        muestra_valida = mv; muestra_in = m;
        @(posedge clk);
        edge_n++;
        if (r) begin
            for (int i = 0; i < N_TAPS; i++) begin xm[i] = '0; cm[i] = '0; end
            exp_q.delete();
            held_s = '0; held_o = 1'b0;
            free_edge = edge_n;
        end else if (edge_n > free_edge) begin
            if (we) cm[a] = d;
            if (mv) begin
                for (int i = N_TAPS - 1; i > 0; i--) xm[i] = xm[i-1];
                xm[0] = m;
                exp_q.push_back(modelo(edge_n));
                free_edge = edge_n + N_TAPS + 1;
            end
        end
        #1;
        reset = 1'b0; coef_we = 1'b0; muestra_valida = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, '0, 0, '0);
    endtask
    task automatic wcoef(input logic [AW-1:0] a, input logic [ANCHO-1:0] d);
        cyc(0, 1, a, d, 0, '0);
    endtask
    task automatic sample(input logic [ANCHO-1:0] m);
        cyc(0, 0, '0, '0, 1, m);
    endtask
    task automatic do_reset();
        cyc(1, 0, '0, '0, 0, '0);
    endtask

    // Monitor: pops the scoreboard on every result pulse and tracks busy/held outputs
    always @(negedge clk) begin
        if (edge_n > 0) begin
            if (salida_valida) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("salida", salida, e.s);
                    chk("overflow", overflow, e.o);
                    chk("latency", edge_n - e.acc_edge + 1, N_TAPS + 2);
                    held_s = e.s;
                    held_o = e.o;
                end
            end else if (exp_q.size() > 0 && edge_n >= exp_q[0].acc_edge + N_TAPS + 1) begin
                chk("missing_valid", 0, 1);
                void'(exp_q.pop_front());
            end
            chk("ocupado", ocupado, (edge_n < free_edge) ? 1 : 0);
            chk("salida_held", salida, held_s);
            chk("overflow_held", overflow, held_o);
        end
    end

    initial begin
        do_reset(); do_reset();
        // single tap passthrough
        wcoef(0, 16'h0100); sample(16'h0280); idle(7);
        // back-to-back unity taps
        do_reset();
        for (int a = 0; a < N_TAPS; a++) wcoef(AW'(a), 16'h0100);
        for (int i = 1; i <= 4; i++) begin sample(ANCHO'(i * 16'h0100)); idle(5); end
        idle(2);
        // positive and negative saturation
        do_reset();
        for (int a = 0; a < N_TAPS; a++) wcoef(AW'(a), 16'h7FFF);
        sample(16'h7FFF); idle(7);
        do_reset();
        for (int a = 0; a < N_TAPS; a++) wcoef(AW'(a), 16'h7FFF);
        sample(16'h8000); idle(7);
        // sample and coefficient write during MAC are dropped
        do_reset();
        wcoef(0, 16'h0100); wcoef(1, 16'h0200); wcoef(2, 16'h0040); wcoef(3, 16'hFF00);
        sample(16'h0100); idle(1);
        cyc(0, 1, '0, 16'h0000, 1, 16'h1234);
        idle(5); sample(16'h0050); idle(7);
        // reset on the second MAC cycle aborts
        do_reset();
        wcoef(0, 16'h0100); sample(16'h0300); idle(1);
        do_reset(); idle(8);
        // rounding boundary
        do_reset();
        wcoef(0, 16'h0080); sample(16'h0001); idle(6); sample(16'hFFFF); idle(7);
        // same-cycle coefficient write and sample
        cyc(0, 1, 0, 16'h0200, 1, 16'h0010); idle(7);
        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(99) == 0), ($urandom_range(3) == 0), AW'($urandom),
                ANCHO'($urandom), ($urandom_range(9) < 4), ANCHO'($urandom));
        end
        idle(10);
        chk("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/secuenciador_mac.md
Name: secuenciador_mac

Overview:
- Time-multiplexed FIR MAC controller in the fixed-point filter datapath.
- Holds the sample delay line and the coefficient bank, and drives one shared signed multiplier across N_TAPS taps, one tap per cycle.
- Accumulates the products at full width, then applies saturating truncation back to the single-width Q format.
- Sits between the sample source and the output register and DAC interface.

Parameters:
- ANCHO, 16, sample/coefficient/output word width (two's complement).
- RESOLUCION, 8, fractional bits (default format Q7.8).
- N_TAPS, 4, number of taps; power of two, at least 2.
- GUARDA, clog2(N_TAPS), extra accumulator guard bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(N_TAPS)  coefficient index.
- coef_dato  in  ANCHO  coefficient value.
- muestra_in  in  ANCHO  new input sample.
- muestra_valida  in  1  sample strobe.
- ocupado  out  1  high while a computation is in progress.
- salida  out  ANCHO  filtered, saturated result.
- salida_valida  out  1  one-cycle pulse when salida updates.
- overflow  out  1  saturation occurred on the current salida.

Behaviour:
- Reset (synchronous, active-high), all registers cleared:
  - delay line x[0..N-1]=0, coefficients c[0..N-1]=0, accumulator=0, index=0.
  - salida=0, salida_valida=0, overflow=0, ocupado=0, state=REPOSO.
- Reset mid-operation aborts the computation; no salida_valida is issued.
- FSM state REPOSO:
  - ocupado=0.
  - On muestra_valida: shift the delay line (x[k]<=x[k-1], x[0]<=muestra_in), clear the accumulator, set index=0, go to MAC.
- FSM state MAC:
  - ocupado=1.
  - Each cycle: acc <= acc + sext(x[index]*c[index]). The product is a signed 2*ANCHO value; the accumulator is 2*ANCHO+GUARDA bits.
  - index increments each cycle. After index=N_TAPS-1 is accumulated, go to SATURA. MAC lasts exactly N_TAPS cycles.
- FSM state SATURA:
  - ocupado=1.
  - Candidate = acc[RESOLUCION+ANCHO-1 : RESOLUCION].
  - If acc[MSB : RESOLUCION+ANCHO-1] are all equal: salida<=candidate, overflow<=0.
  - Else if acc MSB=0: salida<={0,1...1}, overflow<=1.
  - Else: salida<={1,0...0}, overflow<=1.
  - salida_valida<=1 for one cycle; go to REPOSO.
- Truncation is floor (bits discarded) unless the optional feature is enabled.
- Latency: if muestra_valida is sampled in REPOSO at edge E, salida_valida is high in cycle E+N_TAPS+2 (default 6 cycles). REPOSO is re-entered in that same cycle, so a new sample is accepted with no dead cycle.
- Throughput: one result per N_TAPS+2 cycles.
- muestra_valida while ocupado=1: ignored; the sample is dropped and the delay line is unchanged.
- Coefficient writes:
  - coef_we while ocupado=0: c[coef_addr]<=coef_dato at the edge.
  - coef_we while ocupado=1: ignored.
  - coef_we and muestra_valida in the same REPOSO cycle: both take effect, and the new coefficient is used by that computation.
- salida and overflow hold their values until the next SATURA.

Optional Feature:
- Macro: SECUENCIADOR_MAC_REDONDEO_EN.
- Defined: SATURA adds 2^(RESOLUCION-1) to the accumulator before the slice and overflow check (round half up). The addition is done at accumulator width, so it cannot wrap.
- Undefined: plain floor truncation, with no extra adder.
- Latency is identical in both cases.

Test Plan:
- Reset; c[0]=0x0100, others 0; muestra 0x0280 -> salida=0x0280, overflow=0, salida_valida exactly 6 cycles after the accept edge, one cycle wide.
- All c=0x0100; samples 0x0100, 0x0200, 0x0300, 0x0400 back-to-back as soon as ocupado=0 -> salida 0x0100, 0x0300, 0x0600, 0x0A00, overflow=0.
- Saturation, after reset with c=0x7FFF:
  - muestra 0x7FFF -> salida=0x7FFF, overflow=1.
  - Then reset again, c=0x7FFF, muestra 0x8000 -> salida=0x8000, overflow=1.
- During MAC: pulse muestra_valida=0x1234 and coef_we (addr 0, 0x0000) -> both ignored, the result matches the prior configuration, and the next computation shows the 0x1234 sample absent from the delay line.
- Assert reset on the 2nd MAC cycle -> no salida_valida, and salida=0, overflow=0, ocupado=0 the next cycle.
- Rounding, c[0]=0x0080:
  - muestra 0x0001 -> salida 0x0000 without the macro, 0x0001 with it.
  - muestra 0xFFFF -> salida 0xFFFF without the macro, 0x0000 with it.
